// File: rtl/trig_pkg.sv
// Shared types for the trigger sequencer: trigger mode and FSM state.
package trig_pkg;

  typedef enum logic [1:0] {
    MODE_STICKY   = 2'd0,
    MODE_PULSE    = 2'd1,
    MODE_PERIODIC = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Raw mode field to enum; the reserved encoding behaves as STICKY.
  function automatic mode_e decode_mode(input logic [1:0] m);
    mode_e r;
    case (m)
      2'd1:    r = MODE_PULSE;
      2'd2:    r = MODE_PERIODIC;
      default: r = MODE_STICKY;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/trig_channel.sv
// One trigger channel: fire detection against the shared counter, fired flag,
// and pulse-width countdown driving the registered trigger output.
module trig_channel
  import trig_pkg::*;
#(
  parameter int CNT_W = 27
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             clr,
  input  logic             en,
  input  mode_e            mode,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  output logic             fire,
  output logic             fired,
  output logic             trig
);

  logic [CNT_W-1:0] wcnt;

  // PERIODIC refires every repetition; the other modes fire at most once.
  assign fire = en && (cnt == delay) && ((mode == MODE_PERIODIC) || !fired);

  // A fire (re)loads the width count and wins over an expiring pulse, so
  // overlapping fires keep the output high continuously.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      trig  <= 1'b0;
      fired <= 1'b0;
      wcnt  <= '0;
    end else if (clr) begin
      trig  <= 1'b0;
      fired <= 1'b0;
      wcnt  <= '0;
    end else if (fire) begin
      trig  <= 1'b1;
      fired <= 1'b1;
      wcnt  <= (width == '0) ? '0 : width - 1'b1;
    end else if (trig && (mode != MODE_STICKY)) begin
      if (wcnt == '0) trig <= 1'b0;
      else            wcnt <= wcnt - 1'b1;
    end
  end

endmodule

// File: rtl/trig_sequencer.sv
// Multi-channel trigger sequencer: shared cycle counter and IDLE/COUNT/HOLD
// FSM, with one trig_channel per output fired at a per-channel delay.
module trig_sequencer
  import trig_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 27
) (
  input  logic                       i_clk,
  input  logic                       i_arst_n,
  input  logic                       i_arm,
  input  logic                       i_abort,
  input  logic [1:0]                 i_mode,
  input  logic [N_CH-1:0][CNT_W-1:0] i_delay,
  input  logic [CNT_W-1:0]           i_width,
  input  logic [CNT_W-1:0]           i_period,
  output logic [N_CH-1:0]            o_trig,
  output logic                       o_busy,
  output logic                       o_done
);

  state_e                    state, state_nxt;
  mode_e                     mode_q;
  logic [N_CH-1:0][CNT_W-1:0] delay_q;
  logic [CNT_W-1:0]          width_q, period_q, cnt;
  logic [N_CH-1:0]           fire, fired;
  logic                      start, done_nxt, en, clr;

  assign en     = (state == ST_COUNT);
  assign o_busy = en;
  assign clr    = start | i_abort;

  // State register
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Next state, arm acceptance and completion strobe; abort overrides all
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    start     = 1'b0;
    if (i_abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (i_arm) begin
            start     = 1'b1;
            state_nxt = ST_COUNT;
          end
        end
        ST_COUNT: begin
          case (mode_q)
            MODE_PULSE: begin
              // Done only once every channel has fired and all pulses ended
              if (&fired && ~|o_trig) begin
                state_nxt = ST_IDLE;
                done_nxt  = 1'b1;
              end
            end
            MODE_PERIODIC: ;
            default: begin
              // Leave on the same edge that raises the last sticky output
              if (&(fired | fire)) begin
                state_nxt = ST_HOLD;
                done_nxt  = 1'b1;
              end
            end
          endcase
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Registered completion strobe
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) o_done <= 1'b0;
    else           o_done <= done_nxt;
  end

  // Configuration snapshot taken only when a sequence is armed
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      mode_q   <= MODE_STICKY;
      delay_q  <= '0;
      width_q  <= '0;
      period_q <= '0;
    end else if (start) begin
      mode_q   <= decode_mode(i_mode);
      delay_q  <= i_delay;
      width_q  <= i_width;
      period_q <= i_period;
    end
  end

  // Shared counter: wraps after period in PERIODIC, saturates otherwise
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (mode_q == MODE_PERIODIC) cnt <= (cnt == period_q) ? '0 : cnt + 1'b1;
      else if (cnt != '1)          cnt <= cnt + 1'b1;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    trig_channel #(.CNT_W(CNT_W)) u_ch (
      .i_clk    (i_clk),
      .i_arst_n (i_arst_n),
      .clr      (clr),
      .en       (en),
      .mode     (mode_q),
      .cnt      (cnt),
      .delay    (delay_q[k]),
      .width    (width_q),
      .fire     (fire[k]),
      .fired    (fired[k]),
      .trig     (o_trig[k])
    );
  end

endmodule

// File: tb/tb_trig_sequencer.sv
// Directed bench for trig_sequencer: main 4-channel instance plus a narrow
// CNT_W=4 instance for counter saturation.
module tb_trig_sequencer;
  localparam int N_CH  = 4;
  localparam int CNT_W = 27;

  logic clk = 1'b0;
  logic arst_n = 1'b0;

  logic                       arm, abort;
  logic [1:0]                 mode;
  logic [N_CH-1:0][CNT_W-1:0] delay;
  logic [CNT_W-1:0]           width, period;
  logic [N_CH-1:0]            trig;
  logic                       busy, done;

  logic            arm2, abort2;
  logic [1:0]      mode2;
  logic [0:0][3:0] delay2;
  logic [3:0]      width2, period2;
  logic [0:0]      trig2;
  logic            busy2, done2;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  trig_sequencer #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_arst_n(arst_n), .i_arm(arm), .i_abort(abort),
    .i_mode(mode), .i_delay(delay), .i_width(width), .i_period(period),
    .o_trig(trig), .o_busy(busy), .o_done(done)
  );

  trig_sequencer #(.N_CH(1), .CNT_W(4)) dut2 (
    .i_clk(clk), .i_arst_n(arst_n), .i_arm(arm2), .i_abort(abort2),
    .i_mode(mode2), .i_delay(delay2), .i_width(width2), .i_period(period2),
    .o_trig(trig2), .o_busy(busy2), .o_done(done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic pulse_bit(input int n, input int d);
    return (n >= d + 1) && (n <= d + 3);
  endfunction

  initial begin
    logic [3:0] exp;
    arm = 0; abort = 0; mode = 0; delay = '0; width = '0; period = '0;
    arm2 = 0; abort2 = 0; mode2 = 0; delay2 = '0; width2 = '0; period2 = '0;

    // Reset state
    tick(); tick();
    chk("rst_trig", 32'(trig), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_trig2", 32'(trig2), 32'h0);
    arst_n = 1'b1;
    tick();

    // STICKY, delay {3,5,5,9}
    mode = 2'd0; delay[0] = 3; delay[1] = 5; delay[2] = 5; delay[3] = 9;
    arm = 1; tick(); arm = 0;
    chk("st_busy0", 32'(busy), 32'h1);
    chk("st_trig0", 32'(trig), 32'h0);
    for (int n = 1; n <= 12; n++) begin
      tick();
      exp = {n >= 10, n >= 6, n >= 6, n >= 4};
      chk($sformatf("st_trig n=%0d", n), 32'(trig), 32'(exp));
      chk($sformatf("st_done n=%0d", n), 32'(done), 32'(n == 10));
      chk($sformatf("st_busy n=%0d", n), 32'(busy), 32'(n < 10));
    end

    // PULSE re-armed from HOLD; inputs scrambled and arm pulsed mid-run
    mode = 2'd1; delay[0] = 2; delay[1] = 2; delay[2] = 4; delay[3] = 6; width = 3;
    arm = 1; tick(); arm = 0;
    chk("pu_clr", 32'(trig), 32'h0);
    chk("pu_busy0", 32'(busy), 32'h1);
    delay[0] = 1; delay[1] = 1; delay[2] = 1; delay[3] = 1; width = 9; mode = 2'd2;
    for (int n = 1; n <= 13; n++) begin
      arm = (n == 3);
      tick();
      exp = {pulse_bit(n, 6), pulse_bit(n, 4), pulse_bit(n, 2), pulse_bit(n, 2)};
      chk($sformatf("pu_trig n=%0d", n), 32'(trig), 32'(exp));
      chk($sformatf("pu_done n=%0d", n), 32'(done), 32'(n == 11));
      chk($sformatf("pu_busy n=%0d", n), 32'(busy), 32'(n < 11));
    end
    arm = 0;

    // PERIODIC period=7, width=0; delay 9 and 8 exceed period, 7 is the edge
    mode = 2'd2; period = 7; width = 0;
    delay[0] = 2; delay[1] = 9; delay[2] = 7; delay[3] = 8;
    arm = 1; tick(); arm = 0;
    for (int n = 1; n <= 24; n++) begin
      tick();
      exp = {1'b0, (n % 8) == 0, 1'b0, (n % 8) == 3};
      chk($sformatf("pe_trig n=%0d", n), 32'(trig), 32'(exp));
      chk($sformatf("pe_done n=%0d", n), 32'(done), 32'h0);
    end
    chk("pe_busy", 32'(busy), 32'h1);
    abort = 1; tick(); abort = 0;
    chk("pe_ab_trig", 32'(trig), 32'h0);
    chk("pe_ab_busy", 32'(busy), 32'h0);
    chk("pe_ab_done", 32'(done), 32'h0);

    // PERIODIC width == period+1: output stays high once started
    period = 3; width = 4; delay[0] = 1; delay[1] = 5; delay[2] = 6; delay[3] = '1;
    arm = 1; tick(); arm = 0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      chk($sformatf("wide_trig n=%0d", n), 32'(trig), 32'(n >= 2));
    end
    abort = 1; tick(); abort = 0;
    chk("wide_ab_trig", 32'(trig), 32'h0);

    // Arm and abort together from IDLE
    arm = 1; abort = 1; tick(); arm = 0; abort = 0;
    chk("aa_busy", 32'(busy), 32'h0);
    chk("aa_trig", 32'(trig), 32'h0);
    tick();
    chk("aa_busy2", 32'(busy), 32'h0);
    chk("aa_done", 32'(done), 32'h0);

    // Abort at counter=4 during STICKY
    mode = 2'd0; delay[0] = 3; delay[1] = 5; delay[2] = 5; delay[3] = 9;
    arm = 1; tick(); arm = 0;
    for (int n = 1; n <= 4; n++) tick();
    chk("sa_trig4", 32'(trig), 32'h1);
    abort = 1; tick(); abort = 0;
    chk("sa_trig", 32'(trig), 32'h0);
    chk("sa_busy", 32'(busy), 32'h0);
    for (int n = 6; n <= 12; n++) begin
      tick();
      chk($sformatf("sa_done n=%0d", n), 32'(done), 32'h0);
    end

    // Reset asserted mid-COUNT
    arm = 1; tick(); arm = 0;
    for (int n = 1; n <= 5; n++) tick();
    chk("rc_trig5", 32'(trig), 32'h1);
    chk("rc_busy5", 32'(busy), 32'h1);
    #2 arst_n = 1'b0;
    #1;
    chk("rc_trig", 32'(trig), 32'h0);
    chk("rc_busy", 32'(busy), 32'h0);
    chk("rc_done", 32'(done), 32'h0);
    #2 arst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      tick();
      chk($sformatf("rc_post n=%0d", n), 32'({done, busy, trig}), 32'h0);
    end

    // CNT_W=4, PULSE, delay=15: counter saturates while pulse runs
    mode2 = 2'd1; delay2[0] = 4'd15; width2 = 4'd8;
    arm2 = 1; tick(); arm2 = 0;
    for (int n = 1; n <= 26; n++) begin
      tick();
      chk($sformatf("sat_p_trig n=%0d", n), 32'(trig2), 32'((n >= 16) && (n <= 23)));
      chk($sformatf("sat_p_done n=%0d", n), 32'(done2), 32'(n == 25));
      chk($sformatf("sat_p_busy n=%0d", n), 32'(busy2), 32'(n < 25));
      if (n == 20) chk("sat_cnt", 32'(dut2.cnt), 32'd15);
    end

    // CNT_W=4, reserved mode (STICKY behaviour), delay=15
    mode2 = 2'd3;
    arm2 = 1; tick(); arm2 = 0;
    for (int n = 1; n <= 18; n++) begin
      tick();
      chk($sformatf("sat_s_trig n=%0d", n), 32'(trig2), 32'(n >= 16));
      chk($sformatf("sat_s_done n=%0d", n), 32'(done2), 32'(n == 16));
      chk($sformatf("sat_s_busy n=%0d", n), 32'(busy2), 32'(n < 16));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
